// File: rtl/wos_param_pkg.sv
// Shared definitions for the filter parameter bank: register indices, FSM states, default width.
package wos_param_pkg;
  localparam int DATA_W_DEF = 8;

  localparam int P_N = 0;
  localparam int P_H = 1;
  localparam int P_W = 2;
  localparam int P_R = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;
endpackage

// File: rtl/param_slot.sv
// One shadow/active register pair. The shadow is host-written; active loads the shadow on apply.
// PARAM_READBACK_EN exposes the shadow value for host readback.
module param_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  input  logic              apply,
`ifdef PARAM_READBACK_EN
  output logic [DATA_W-1:0] shadow,
`endif
  output logic [DATA_W-1:0] active
);
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] active_q, active_d;

  // Apply samples the pre-write shadow, so a same-edge write waits for the next commit.
  always_comb begin
    shadow_d = we    ? din      : shadow_q;
    active_d = apply ? shadow_q : active_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

`ifdef PARAM_READBACK_EN
  assign shadow = shadow_q;
`endif
  assign active = active_q;
endmodule

// File: rtl/param_bank.sv
// Filter parameter bank: host-written shadow registers, committed to the active copy only while
// the filter is idle. Optional shadow readback port under PARAM_READBACK_EN.
module param_bank import wos_param_pkg::*; #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_PARAMS = 4,
  parameter int SEL_W      = 3,
  parameter int GEN_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         w_en,
  input  logic [SEL_W-1:0]             sel,
  input  logic [DATA_W-1:0]            in,
  input  logic                         commit_req,
  input  logic                         filt_busy,
  input  logic                         err_clr,
`ifdef PARAM_READBACK_EN
  input  logic [SEL_W-1:0]             rd_sel,
  output logic [DATA_W-1:0]            rd_data,
`endif
  output logic [NUM_PARAMS*DATA_W-1:0] params,
  output logic                         pending,
  output logic                         commit_ack,
  output logic [GEN_W-1:0]             cfg_gen,
  output logic                         addr_err
);
  localparam logic [SEL_W:0] NP = (SEL_W+1)'(NUM_PARAMS);

  state_e             state_q, state_d;
  logic               pending_q, pending_d;
  logic               ack_q, ack_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic               err_q, err_d;
  logic               apply;
  logic               bad_wr;

  logic [NUM_PARAMS-1:0][DATA_W-1:0] active_w;
`ifdef PARAM_READBACK_EN
  logic [NUM_PARAMS-1:0][DATA_W-1:0] shadow_w;
  logic [DATA_W-1:0]                 rd_data_q, rd_data_d;
`endif

  always_comb begin
    apply   = (state_q == PENDING) && !filt_busy;
    bad_wr  = w_en && ({1'b0, sel} >= NP);
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_req) state_d = PENDING;
      PENDING: if (!filt_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pending_d = (state_d == PENDING);
    ack_d     = apply;
    gen_d     = apply ? gen_q + GEN_W'(1) : gen_q;
    // A new bad write beats a same-cycle clear.
    err_d     = bad_wr ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      gen_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      gen_q     <= gen_d;
      err_q     <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_slot
    localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
    param_slot #(.DATA_W(DATA_W)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (w_en && (sel == IDX)),
      .din    (in),
      .apply  (apply),
`ifdef PARAM_READBACK_EN
      .shadow (shadow_w[i]),
`endif
      .active (active_w[i])
    );
  end

`ifdef PARAM_READBACK_EN
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_PARAMS; i++)
      if ({1'b0, rd_sel} == (SEL_W+1)'(i)) rd_data_d = shadow_w[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

  assign params     = active_w;
  assign pending    = pending_q;
  assign commit_ack = ack_q;
  assign cfg_gen    = gen_q;
  assign addr_err   = err_q;
endmodule

// File: tb/tb_param_bank.sv
// Randomized scoreboard bench for param_bank; a per-cycle behavioural model predicts outputs.
module tb_param_bank;
  localparam int DW = 8;
  localparam int NP = 4;
  localparam int SW = 3;
  localparam int GW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic d_wen, d_req, d_busy, d_clr;
  logic [SW-1:0] d_sel, d_rdsel;
  logic [DW-1:0] d_in;
  logic [NP*DW-1:0] params;
  logic pending, commit_ack, addr_err;
  logic [GW-1:0] cfg_gen;
  logic [DW-1:0] rd_data;

  always #5 clk = ~clk;

  param_bank #(.DATA_W(DW), .NUM_PARAMS(NP), .SEL_W(SW), .GEN_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .w_en(d_wen), .sel(d_sel), .in(d_in),
    .commit_req(d_req), .filt_busy(d_busy), .err_clr(d_clr),
`ifdef PARAM_READBACK_EN
    .rd_sel(d_rdsel), .rd_data(rd_data),
`endif
    .params(params), .pending(pending), .commit_ack(commit_ack),
    .cfg_gen(cfg_gen), .addr_err(addr_err)
  );

`ifndef PARAM_READBACK_EN
  assign rd_data = '0;
`endif

  // Reference model state
  int m_sh[NP];
  int m_act[NP];
  int m_gen, m_rd;
  bit m_pend, m_ack, m_err;
  typedef struct { logic [NP*DW-1:0] p; int gen; } exp_t;
  exp_t sb_q[$];

  int n_chk = 0, n_fail = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NP*DW-1:0] pack_act();
    logic [NP*DW-1:0] r;
    for (int i = 0; i < NP; i++) r[i*DW +: DW] = DW'(m_act[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin m_sh[i] = 0; m_act[i] = 0; end
    m_gen = 0; m_rd = 0; m_pend = 0; m_ack = 0; m_err = 0;
    sb_q.delete();
  endtask

  // One clock edge worth of specified behaviour; reads only bench-driven inputs.
  task automatic model_edge();
    exp_t e;
    m_ack = 0;
    m_rd  = (int'(d_rdsel) < NP) ? m_sh[d_rdsel] : 0;
    if (m_pend && !d_busy) begin
      for (int i = 0; i < NP; i++) m_act[i] = m_sh[i];
      m_gen  = (m_gen + 1) % (1 << GW);
      m_pend = 0;
      m_ack  = 1;
      e.p = pack_act(); e.gen = m_gen;
      sb_q.push_back(e);
    end else if (!m_pend && d_req) m_pend = 1;
    if (d_wen && int'(d_sel) < NP) m_sh[d_sel] = int'(d_in);
    if (d_wen && int'(d_sel) >= NP) m_err = 1;
    else if (d_clr) m_err = 0;
  endtask

  // Monitor: every cycle compare against the model; on each ack pop the scoreboard.
  always @(negedge clk) if (started) begin
    exp_t e;
    chk("pending", 64'(pending), 64'(m_pend));
    chk("commit_ack", 64'(commit_ack), 64'(m_ack));
    chk("addr_err", 64'(addr_err), 64'(m_err));
    chk("params", 64'(params), 64'(pack_act()));
`ifdef PARAM_READBACK_EN
    chk("rd_data", 64'(rd_data), 64'(m_rd));
`endif
    if (commit_ack) begin
      if (sb_q.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
      else begin
        e = sb_q.pop_front();
        chk("sb_params", 64'(params), 64'(e.p));
        chk("sb_cfg_gen", 64'(cfg_gen), 64'(e.gen));
      end
    end
  end

  // Drive at negedge, advance model at posedge, return at next negedge.
  task automatic step(input bit wen, input int sel, input int din,
                      input bit req, input bit busy, input bit clr);
    d_wen = wen; d_sel = SW'(sel); d_in = DW'(din);
    d_req = req; d_busy = busy; d_clr = clr;
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    idle(1);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    d_wen = 0; d_sel = '0; d_in = '0; d_req = 0; d_busy = 0; d_clr = 0; d_rdsel = '0;
    model_reset();
    @(negedge clk);
    started = 1;
    chk("reset_params", 64'(params), 64'(0));
    chk("reset_cfg_gen", 64'(cfg_gen), 64'(0));
    rst_n = 1'b1;
    idle(2);

    // Reset mid-commit
    step(1, 1, 8'h05, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("pending_before_rst", 64'(pending), 64'(1));
    do_reset();
    idle(3);
    chk("rst_params", 64'(params), 64'(0));
    chk("rst_cfg_gen", 64'(cfg_gen), 64'(0));

    // Basic commit
    step(1, 0, 9, 0, 0, 0);
    step(1, 1, 3, 0, 0, 0);
    step(1, 2, 3, 0, 0, 0);
    step(1, 3, 4, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("no_ack_after_1", 64'(commit_ack), 64'(0));
    idle(1);
    chk("ack_after_2", 64'(commit_ack), 64'(1));
    chk("basic_params", 64'(params), 64'h04030309);
    chk("basic_gen", 64'(cfg_gen), 64'(1));

    // Busy hold with a write during the hold
    step(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) step(i == 4, 1, 5, i < 3, 1, 0);
    chk("hold_params", 64'(params), 64'h04030309);
    step(0, 0, 0, 0, 0, 0);
    chk("hold_ack", 64'(commit_ack), 64'(1));
    chk("hold_h", 64'(params[15:8]), 64'(5));

    // Write colliding with the apply edge
    step(0, 0, 0, 1, 0, 0);
    step(1, 2, 7, 0, 0, 0);
    chk("collide_w_old", 64'(params[23:16]), 64'(3));
    step(0, 0, 0, 1, 0, 0);
    idle(1);
    chk("collide_w_new", 64'(params[23:16]), 64'(7));
    chk("collide_gen", 64'(cfg_gen), 64'(4));

    // Bad address handling
    step(1, 5, 8'hFF, 0, 0, 0);
    idle(2);
    chk("bad_err", 64'(addr_err), 64'(1));
    step(0, 0, 0, 0, 0, 1);
    chk("bad_clr", 64'(addr_err), 64'(0));
    step(1, 6, 8'hFF, 0, 0, 0);
    step(1, 7, 8'hAA, 0, 0, 1);
    chk("bad_set_wins", 64'(addr_err), 64'(1));
    step(0, 0, 0, 1, 0, 1);
    idle(1);
    chk("bad_no_change", 64'(params), 64'h04070509);

    // Generation counter wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1, i % NP, i, 1, 0, 0);
      idle(1);
    end
    chk("wrap_gen", 64'(cfg_gen), 64'(0));

`ifdef PARAM_READBACK_EN
    step(1, 2, 8'h3C, 0, 0, 0);
    d_rdsel = SW'(2);
    idle(1);
    chk("readback", 64'(rd_data), 64'h3C);
    d_rdsel = SW'(6);
    idle(1);
    chk("readback_oob", 64'(rd_data), 64'(0));
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      d_rdsel = SW'($urandom_range(0, (1 << SW) - 1));
      step($urandom_range(0, 2) == 0, $urandom_range(0, (1 << SW) - 1), $urandom_range(0, 255),
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      if (i == 300) do_reset();
    end
    idle(3);
    chk("sb_drained", 64'(sb_q.size()), 64'(0));

    started = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/param_bank.md
Name: param_bank

Overview:
- Parametrised successor of the 4-register filter parameter file (n, h, w, r) for the weighted order statistics 2D filter datapath.
- Holds NUM_PARAMS shadow registers written by the host through a sel/in/w_en port, plus an active copy that drives the filter.
- Shadow is copied to active only on a commit handshake, and only while the filter is not busy, so the filter never sees a half-updated configuration mid-frame.
- Adds address checking and a configuration generation counter.

Parameters:
- DATA_W, 8, width of each parameter register
- NUM_PARAMS, 4, number of parameter registers (index 0=n, 1=h, 2=w, 3=r; extra indices are spare)
- SEL_W, 3, width of sel; must satisfy 2**SEL_W >= NUM_PARAMS
- GEN_W, 4, width of the commit generation counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- w_en  in  1  shadow write strobe
- sel  in  SEL_W  shadow register index
- in  in  DATA_W  write data
- commit_req  in  1  request shadow->active transfer (level or pulse)
- filt_busy  in  1  filter is mid-frame; blocks the transfer
- err_clr  in  1  clears addr_err
- params  out  NUM_PARAMS*DATA_W  active registers, index i at bits [i*DATA_W +: DATA_W]
- pending  out  1  commit requested, not yet applied
- commit_ack  out  1  one-cycle pulse, active registers just updated
- cfg_gen  out  GEN_W  count of applied commits, wraps
- addr_err  out  1  sticky: write attempted with sel >= NUM_PARAMS

Behaviour:
- Reset (async on rst_n low): all shadow and active registers 0, params 0, pending 0, commit_ack 0, cfg_gen 0, addr_err 0, FSM in IDLE. Reset mid-commit abandons the commit; nothing partial is applied.
- Shadow write: on a clk edge with w_en=1 and sel<NUM_PARAMS, shadow[sel] <= in. Active registers are never written directly.
- Bad address: w_en=1 with sel>=NUM_PARAMS writes nothing and sets addr_err.
- addr_err: cleared by err_clr. err_clr and a new bad write in the same cycle leave addr_err=1 (set wins).
- FSM, two states:
  - IDLE: commit_req=1 -> PENDING on the next edge, pending=1.
  - PENDING, filt_busy=1: hold. commit_req is ignored (requests merge).
  - PENDING, filt_busy=0: on that edge, active <= shadow for all indices simultaneously, commit_ack <= 1 for exactly one cycle, cfg_gen <= cfg_gen+1 (wraps modulo 2**GEN_W), pending <= 0, return to IDLE.
- Latency: minimum 2 edges from the edge that samples commit_req to commit_ack/params visible.
- Write in the same cycle as the apply edge: the write lands in shadow only; active takes the pre-write shadow value. The write is picked up by the next commit.
- Writes while PENDING are allowed and are included if they occur before the apply edge.
- commit_req=1 in the cycle commit_ack is high starts a new PENDING.
- params is purely registered from the active copy; no combinational path from in.

Optional Feature:
- Macro PARAM_READBACK_EN.
- Defined: adds input rd_sel[SEL_W] and output rd_data[DATA_W]. rd_data is registered, one-cycle latency, returns shadow[rd_sel]; returns 0 for rd_sel>=NUM_PARAMS; reset value 0.
- Undefined: these ports and their logic do not exist.

Decomposition:
- Shared package wos_param_pkg holds:
  - index constants P_N=0, P_H=1, P_W=2, P_R=3
  - the FSM state typedef (IDLE, PENDING)
  - default DATA_W
- One sub-module is natural: param_slot, a single shadow/active register pair with write-enable and apply inputs, instantiated NUM_PARAMS times.
- FSM, address check and generation counter stay in the top.

Test Plan:
- Reset: write shadow[1]=0x05, assert rst_n=0 mid-PENDING -> params=0, pending=0, cfg_gen=0, no commit_ack.
- Basic commit: write n=9, h=3, w=3, r=4, pulse commit_req with filt_busy=0 -> commit_ack high 2 edges later, params={r=4,w=3,h=3,n=9}, cfg_gen=1.
- Busy hold: commit_req with filt_busy=1 for 10 cycles -> pending=1, params unchanged. Drop filt_busy -> ack next edge. Write h=5 during the hold -> applied value h=5.
- Apply-cycle collision: write w=7 on the same edge as the apply -> params w keeps its old value, shadow w=7. A second commit -> params w=7, cfg_gen increments again.
- Bad address: NUM_PARAMS=4, w_en with sel=5, in=0xFF -> no register changes, addr_err=1 until err_clr. err_clr plus another bad write in the same cycle -> addr_err stays 1.
- Wrap: 16 commits with GEN_W=4 -> cfg_gen returns to 0. With PARAM_READBACK_EN, rd_sel=2 -> rd_data=shadow[2] one cycle later.
